// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome encoding and the pending-branch record.
// No logic; types and defaults only.
// The ADDR_WIDTH macro sets the PC width (32 if not defined elsewhere).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

  localparam int CORE_ADDR_WIDTH            = `ADDR_WIDTH;
  localparam int BRANCH_QUEUE_DEPTH_DEFAULT = 4;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  // One predicted conditional branch waiting for EX to resolve it.
  typedef struct packed {
    logic [CORE_ADDR_WIDTH-1:0] pc;
    BranchOutcome               prediction;
    logic [CORE_ADDR_WIDTH-1:0] recovery_target;
  } branch_pending_t;

endpackage

// File: rtl/branch_pending_fifo.sv
// In-order pending-branch queue: storage, wrap-bit pointers, push/pop/clear.
// Latency: push visible at head one cycle later; empty/count are registered.
// Backpressure: push ignored when full (no same-cycle pop bypass); clear wins over push.
module branch_pending_fifo
  import mips_core_pkg::*;
#(
  parameter int DEPTH = BRANCH_QUEUE_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  branch_pending_t       i_push_dat,
  input  logic                  i_pop,
  input  logic                  i_clear,
  output branch_pending_t       o_head_dat,
  output logic                  o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int            AW      = $clog2(DEPTH);
  localparam int            PW      = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  branch_pending_t mem_q [DEPTH];
  branch_pending_t mem_d [DEPTH];
  logic            full;

  // The extra pointer bit separates full (MSBs differ) from empty (equal).
  assign o_count    = wr_ptr_q - rd_ptr_q;
  assign o_empty    = (wr_ptr_q == rd_ptr_q);
  assign full       = (o_count == DEPTH_P);
  assign o_head_dat = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers and storage: clear drops everything left after this cycle's pop,
  // including any same-cycle push.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_pop && !o_empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (i_clear) begin
      rd_ptr_d = wr_ptr_q;
    end else if (i_push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = i_push_dat;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves queued branch predictions against EX outcomes; emits predictor feedback and mispredict redirects.
// Latency: feedback/redirect registered, one cycle after the resolving i_ex_valid.
// Backpressure: o_dec_ready low when queue full; pushes while not ready are dropped. Stats gated by BRANCH_STATS_EN.
module branch_resolver
  import mips_core_pkg::*;
#(
  parameter int DEPTH      = BRANCH_QUEUE_DEPTH_DEFAULT,
  parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_dec_valid,
  input  logic [ADDR_WIDTH-1:0] i_dec_pc,
  input  logic                  i_dec_prediction,
  input  logic [ADDR_WIDTH-1:0] i_dec_recovery_target,
  output logic                  o_dec_ready,
  input  logic                  i_ex_valid,
  input  logic                  i_ex_cond_true,
  input  logic                  i_flush,
  output logic                  o_fb_valid,
  output logic [ADDR_WIDTH-1:0] o_fb_pc,
  output logic                  o_fb_prediction,
  output logic                  o_fb_outcome,
  output logic                  o_redirect_valid,
  output logic [ADDR_WIDTH-1:0] o_redirect_pc,
  output logic                  o_empty,
  output logic                  o_underflow,
  output logic [31:0]           o_stat_resolved,
  output logic [31:0]           o_stat_mispredict
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  branch_pending_t push_dat;
  branch_pending_t head;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            resolve;
  logic            mispredict;
  BranchOutcome    outcome;

  logic                  fb_valid_q, fb_valid_d;
  logic [ADDR_WIDTH-1:0] fb_pc_q, fb_pc_d;
  BranchOutcome          fb_prediction_q, fb_prediction_d;
  BranchOutcome          fb_outcome_q, fb_outcome_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                  underflow_q, underflow_d;

  // Ready depends only on the registered count, so a pop cannot free a slot for the same cycle.
  assign o_dec_ready = (fifo_count < DEPTH_C);
  assign o_empty     = fifo_empty;

  // Resolve only when something is pending; a wrong guess squashes everything younger.
  always_comb begin
    push_dat                 = '0;
    push_dat.pc              = i_dec_pc;
    push_dat.prediction      = BranchOutcome'(i_dec_prediction);
    push_dat.recovery_target = i_dec_recovery_target;
    resolve                  = i_ex_valid && !fifo_empty;
    outcome                  = i_ex_cond_true ? TAKEN : NOT_TAKEN;
    mispredict               = resolve && (outcome != head.prediction);
  end

  branch_pending_fifo #(
    .DEPTH (DEPTH)
  ) u_pending (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (i_dec_valid),
    .i_push_dat (push_dat),
    .i_pop      (resolve),
    .i_clear    (mispredict || i_flush),
    .o_head_dat (head),
    .o_empty    (fifo_empty),
    .o_count    (fifo_count)
  );

  // Output record: pulses for one cycle, payload fields hold between pulses.
  always_comb begin
    fb_valid_d       = resolve;
    fb_pc_d          = fb_pc_q;
    fb_prediction_d  = fb_prediction_q;
    fb_outcome_d     = fb_outcome_q;
    redirect_valid_d = mispredict;
    redirect_pc_d    = redirect_pc_q;
    underflow_d      = underflow_q || (i_ex_valid && fifo_empty);
    if (resolve) begin
      fb_pc_d         = head.pc;
      fb_prediction_d = head.prediction;
      fb_outcome_d    = outcome;
    end
    if (mispredict) begin
      redirect_pc_d = head.recovery_target;
    end
  end

  // Output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fb_valid_q       <= 1'b0;
      fb_pc_q          <= '0;
      fb_prediction_q  <= NOT_TAKEN;
      fb_outcome_q     <= NOT_TAKEN;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      underflow_q      <= 1'b0;
    end else begin
      fb_valid_q       <= fb_valid_d;
      fb_pc_q          <= fb_pc_d;
      fb_prediction_q  <= fb_prediction_d;
      fb_outcome_q     <= fb_outcome_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      underflow_q      <= underflow_d;
    end
  end

  assign o_fb_valid       = fb_valid_q;
  assign o_fb_pc          = fb_pc_q;
  assign o_fb_prediction  = fb_prediction_q;
  assign o_fb_outcome     = fb_outcome_q;
  assign o_redirect_valid = redirect_valid_q;
  assign o_redirect_pc    = redirect_pc_q;
  assign o_underflow      = underflow_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_resolved_q, stat_resolved_d;
  logic [31:0] stat_mispredict_q, stat_mispredict_d;

  // Saturating counters advance together with the pulses they count; flush does not touch them.
  always_comb begin
    stat_resolved_d   = stat_resolved_q;
    stat_mispredict_d = stat_mispredict_q;
    if (resolve && (stat_resolved_q != 32'hFFFF_FFFF)) begin
      stat_resolved_d = stat_resolved_q + 32'd1;
    end
    if (mispredict && (stat_mispredict_q != 32'hFFFF_FFFF)) begin
      stat_mispredict_d = stat_mispredict_q + 32'd1;
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_resolved_q   <= '0;
      stat_mispredict_q <= '0;
    end else begin
      stat_resolved_q   <= stat_resolved_d;
      stat_mispredict_q <= stat_mispredict_d;
    end
  end

  assign o_stat_resolved   = stat_resolved_q;
  assign o_stat_mispredict = stat_mispredict_q;
`else
  assign o_stat_resolved   = '0;
  assign o_stat_mispredict = '0;
`endif

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Feedback-side counterpart of the branch prediction request path.
- Holds every conditional branch predicted at decode in a small in-order pending queue.
- Resolves the oldest entry when EX reports the branch condition, and emits the feedback record (valid, pc, prediction, outcome) consumed by the predictor.
- Emits a redirect (recovery target) to the hazard controller on mispredict and squashes all younger queued branches.

Parameters:
- DEPTH, 4, pending-queue entries; power of two, ≥2.
- ADDR_WIDTH, `ADDR_WIDTH (32), PC/target width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_dec_valid  in  1  decode pushes a predicted conditional branch (non-jump)
- i_dec_pc  in  ADDR_WIDTH  PC of the branch
- i_dec_prediction  in  1  BranchOutcome predicted at decode
- i_dec_recovery_target  in  ADDR_WIDTH  PC to fetch if prediction wrong
- o_dec_ready  out  1  queue can accept a push this cycle
- i_ex_valid  in  1  oldest pending branch resolves this cycle
- i_ex_cond_true  in  1  ALU branch condition result
- i_flush  in  1  external pipeline flush (exception/reset of front end)
- o_fb_valid  out  1  feedback record valid (one-cycle pulse)
- o_fb_pc  out  ADDR_WIDTH  PC of resolved branch
- o_fb_prediction  out  1  stored prediction
- o_fb_outcome  out  1  actual outcome
- o_redirect_valid  out  1  mispredict redirect pulse
- o_redirect_pc  out  ADDR_WIDTH  stored recovery target
- o_empty  out  1  no pending branches
- o_underflow  out  1  sticky: i_ex_valid seen while empty
- o_stat_resolved  out  32  resolved-branch count (optional feature)
- o_stat_mispredict  out  32  mispredict count (optional feature)

Behaviour:
- Reset: queue empty, pointers 0; o_empty=1, o_dec_ready=1, o_underflow=0. All o_fb_*, o_redirect_*, o_stat_* = 0; o_fb_prediction/o_fb_outcome = NOT_TAKEN.
- Queue: circular FIFO with read/write pointers of log2(DEPTH)+1 bits; the extra wrap bit distinguishes full from empty.
- o_dec_ready = (count < DEPTH), combinational from registered count. No same-cycle pop bypass: when full, a push is refused even if a pop occurs.
- Push: i_dec_valid & o_dec_ready stores {pc, prediction, recovery_target} at write pointer. i_dec_valid while not ready is dropped; decode must stall on ~o_dec_ready.
- Resolve (i_ex_valid & ~o_empty):
  - Pop the head entry.
  - outcome = i_ex_cond_true ? TAKEN : NOT_TAKEN; mispredict = (outcome != head.prediction).
  - Next cycle (latency 1, registered): o_fb_valid=1 with head pc/prediction/outcome; o_redirect_valid=mispredict, o_redirect_pc=head.recovery_target.
  - Pulses last exactly one cycle. o_fb_pc/o_redirect_pc hold their last value when not valid.
- Mispredict squash: in the resolve cycle, all remaining entries are discarded (read pointer := write pointer after pop) and any same-cycle push is discarded. The queue is empty next cycle.
- Correct prediction: the same-cycle push and pop both take effect; count unchanged.
- i_ex_valid while empty: ignored (no feedback pulse); o_underflow set, cleared only by reset.
- i_flush: queue emptied next cycle; same-cycle push discarded. A same-cycle resolve still produces feedback/redirect (older than the flush cause).
- Reset mid-operation: everything returns to reset state in one cycle; pending entries lost, no pulses emitted.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: o_stat_resolved increments on every feedback pulse; o_stat_mispredict increments on every redirect pulse. Both are 32-bit saturating at 32'hFFFF_FFFF and cleared on reset; they are not affected by i_flush.
- Undefined: no counter registers; both ports are tied to 0.

Decomposition:
- mips_core_pkg (existing): reuse the BranchOutcome enum. Add typedef branch_pending_t (struct: pc, prediction, recovery_target) and localparam BRANCH_QUEUE_DEPTH_DEFAULT=4.
- Sub-module branch_pending_fifo: storage, pointers, push/pop/clear, full/empty/count.
- branch_resolver holds the compare logic, output registers and stats.

Test Plan:
- Reset then push pc=0x100, pred=TAKEN, rec=0x108; i_ex_valid with cond_true=1 -> next cycle o_fb_valid=1, pc=0x100, outcome=TAKEN; o_redirect_valid=0; o_empty=1.
- Push pc=0x200, pred=NOT_TAKEN, rec=0x240, then 0x204 and 0x208; resolve head with cond_true=1 -> o_redirect_valid=1, pc=0x240; queue empty next cycle; a further i_ex_valid sets o_underflow=1.
- Push 4 entries (DEPTH=4) -> o_dec_ready=0. A 5th push plus a correct resolve in the same cycle -> 5th push dropped, count=3, o_dec_ready=1 next cycle.
- Push 0x300 and 0x304 wrapping pointers past index 3; resolve both correctly back-to-back -> two consecutive o_fb_valid pulses with pc 0x300 then 0x304, in order.
- i_flush with 3 pending plus a same-cycle resolve of a mispredict -> redirect pulse issued; o_empty=1 next cycle; that cycle's push is ignored.
- With BRANCH_STATS_EN: 5 resolves (2 mispredicts) -> o_stat_resolved=5, o_stat_mispredict=2. Without the macro -> both read 0.
